// File: rtl/issue_slot_mp.sv
// Out-of-order issue-queue entry: operand wakeup, issue request, one-cycle replay window, branch kill/clear.
// Optional ISSUE_SLOT_AGE_EN: o_priority becomes a saturating age counter instead of the stored pry field.
//   state     | meaning
//   S_INVALID | slot empty
//   S_WAIT    | holds an op, at least one source not ready
//   S_READY   | all sources ready, requesting issue
//   S_ISSUED  | granted last cycle, replay window open
module issue_slot_mp #(
    parameter int WIDTH_REG = 6,
    parameter int WIDTH_TAG = 3,
    parameter int WIDTH_BRM = 4,
    parameter int WIDTH_PRY = 2,
    parameter int NUM_SRC   = 2,
    parameter int NUM_WB    = 4,
    parameter int WIDTH_I   = WIDTH_BRM + WIDTH_TAG + (NUM_SRC + 1) * WIDTH_REG + WIDTH_PRY + 1 + NUM_SRC,
    parameter int WIDTH_O   = WIDTH_BRM + WIDTH_TAG + (NUM_SRC + 1) * WIDTH_REG
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_en,
    input  logic [WIDTH_I-1:0]          i_data,
    input  logic [NUM_WB*WIDTH_REG-1:0] i_wdest,
    input  logic [NUM_WB-1:0]           i_wdest_vld,
    input  logic [WIDTH_BRM-1:0]        i_brkill,
    input  logic [WIDTH_BRM-1:0]        i_brclr,
    input  logic                        i_grant,
    input  logic                        i_nack,
    output logic                        o_valid,
    output logic                        o_request,
    output logic [WIDTH_PRY-1:0]        o_priority,
    output logic [WIDTH_O-1:0]          o_rslot,
    output logic [WIDTH_I-1:0]          o_data
);
    localparam int OFF_VAL = NUM_SRC;
    localparam int OFF_PRY = NUM_SRC + 1;
    localparam int OFF_RS  = OFF_PRY + WIDTH_PRY;
    localparam int OFF_RD  = OFF_RS + NUM_SRC * WIDTH_REG;
    localparam int OFF_TAG = OFF_RD + WIDTH_REG;
    localparam int OFF_BRM = OFF_TAG + WIDTH_TAG;

    typedef enum logic [1:0] {S_INVALID, S_WAIT, S_READY, S_ISSUED} state_t;

    state_t                      r_state, w_state_nxt, w_hold_nxt;
    logic [WIDTH_BRM-1:0]        r_brmask;
    logic [WIDTH_TAG-1:0]        r_tag;
    logic [WIDTH_REG-1:0]        r_rd;
    logic [NUM_SRC*WIDTH_REG-1:0] r_rs;
    logic [WIDTH_PRY-1:0]        r_pry;
    logic [NUM_SRC-1:0]          r_p;

    logic [WIDTH_BRM-1:0]        w_in_brm;
    logic [NUM_SRC*WIDTH_REG-1:0] w_in_rs;
    logic [NUM_SRC-1:0]          w_in_p;
    logic                        w_in_val;
    logic [NUM_SRC-1:0]          w_wake, w_wake_in, w_p_nxt, w_p_in;
    logic                        w_kill, w_kill_in, w_fire, w_hold_val;

    assign w_in_brm = i_data[OFF_BRM +: WIDTH_BRM];
    assign w_in_rs  = i_data[OFF_RS +: NUM_SRC*WIDTH_REG];
    assign w_in_p   = i_data[NUM_SRC-1:0];
    assign w_in_val = i_data[OFF_VAL];

    always_comb begin
        w_wake    = '0;
        w_wake_in = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int j = 0; j < NUM_WB; j++) begin
                if (i_wdest_vld[j] && (i_wdest[j*WIDTH_REG +: WIDTH_REG] == r_rs[k*WIDTH_REG +: WIDTH_REG]))
                    w_wake[k] = 1'b1;
                if (i_wdest_vld[j] && (i_wdest[j*WIDTH_REG +: WIDTH_REG] == w_in_rs[k*WIDTH_REG +: WIDTH_REG]))
                    w_wake_in[k] = 1'b1;
            end
        end
    end

    assign w_p_nxt   = r_p | w_wake;
    assign w_p_in    = w_in_p | w_wake_in;
    assign w_kill    = (r_state != S_INVALID) && (|(r_brmask & i_brkill));
    assign w_kill_in = |(w_in_brm & i_brkill);
    assign o_request = (r_state == S_READY) && !(|(r_brmask & i_brkill));
    assign w_fire    = o_request && i_grant;

    // w_hold_nxt is the transition of the stored entry alone; a write only overrides it.
    always_comb begin
        w_hold_nxt = r_state;
        case (r_state)
            S_INVALID: w_hold_nxt = S_INVALID;
            S_WAIT:    w_hold_nxt = (&w_p_nxt) ? S_READY : S_WAIT;
            S_READY:   w_hold_nxt = w_fire ? S_ISSUED : S_READY;
            S_ISSUED:  w_hold_nxt = i_nack ? S_READY : S_INVALID;
            default:   w_hold_nxt = S_INVALID;
        endcase
        if (w_kill)
            w_hold_nxt = S_INVALID;
        w_state_nxt = w_hold_nxt;
        if (i_en)
            w_state_nxt = !w_in_val ? S_INVALID : ((&w_p_in) ? S_READY : S_WAIT);
        if (w_kill || (i_en && w_kill_in))
            w_state_nxt = S_INVALID;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_INVALID;
            r_brmask <= '0;
            r_tag    <= '0;
            r_rd     <= '0;
            r_rs     <= '0;
            r_pry    <= '0;
            r_p      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (i_en) begin
                r_brmask <= w_in_brm & ~i_brclr;
                r_tag    <= i_data[OFF_TAG +: WIDTH_TAG];
                r_rd     <= i_data[OFF_RD +: WIDTH_REG];
                r_rs     <= w_in_rs;
                r_pry    <= i_data[OFF_PRY +: WIDTH_PRY];
                r_p      <= w_p_in;
            end else begin
                r_brmask <= r_brmask & ~i_brclr;
                r_p      <= w_p_nxt;
            end
        end
    end

`ifdef ISSUE_SLOT_AGE_EN
    logic [WIDTH_PRY-1:0] r_age;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_age <= '0;
        end else if (i_en) begin
            r_age <= '0;
        end else if (r_state == S_ISSUED) begin
            if (i_nack)
                r_age <= '1;
        end else if ((r_state == S_WAIT) || (r_state == S_READY)) begin
            if (r_age != '1)
                r_age <= r_age + 1'b1;
        end
    end

    assign o_priority = r_age;
`else
    assign o_priority = r_pry;
`endif

    // Compaction view: the entry's own next-cycle contents, independent of any write into this slot.
    assign w_hold_val = (w_hold_nxt == S_WAIT) || (w_hold_nxt == S_READY);
    assign o_valid    = (r_state != S_INVALID);
    assign o_rslot    = ((r_state == S_READY) || (r_state == S_ISSUED)) ? {r_brmask, r_tag, r_rd, r_rs} : '0;
    assign o_data     = {r_brmask & ~i_brclr, r_tag, r_rd, r_rs, r_pry, w_hold_val, w_p_nxt};

endmodule

// File: tb/tb_issue_slot_mp.sv
// Self-checking bench for issue_slot_mp: directed scenarios plus randomized cycles against a behavioural model.
module tb_issue_slot_mp;
    localparam int REG = 6, TAG = 3, BRM = 4, PRY = 2, NS = 2, NWB = 4;
    localparam int WI = 30, WO = 25;
    localparam int O_RD = 17, O_BRM = 26;

    logic               i_clk = 1'b0, i_rst_n = 1'b0;
    logic               i_en, i_grant, i_nack;
    logic [WI-1:0]      i_data;
    logic [NWB*REG-1:0] i_wdest;
    logic [NWB-1:0]     i_wdest_vld;
    logic [BRM-1:0]     i_brkill, i_brclr;
    logic               o_valid, o_request;
    logic [PRY-1:0]     o_priority;
    logic [WO-1:0]      o_rslot;
    logic [WI-1:0]      o_data;

    int n_pass = 0, n_total = 0;

    // model: state 0 empty, 1 waiting, 2 ready, 3 issued
    int             m_st;
    logic [BRM-1:0] m_brm;
    logic [TAG-1:0] m_tag;
    logic [REG-1:0] m_rd;
    logic [REG-1:0] m_rs [NS];
    logic [PRY-1:0] m_pry, m_age;
    logic [NS-1:0]  m_p;

    always #5 i_clk = ~i_clk;

    issue_slot_mp #(.WIDTH_REG(REG), .WIDTH_TAG(TAG), .WIDTH_BRM(BRM), .WIDTH_PRY(PRY),
                    .NUM_SRC(NS), .NUM_WB(NWB)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_data(i_data),
        .i_wdest(i_wdest), .i_wdest_vld(i_wdest_vld), .i_brkill(i_brkill), .i_brclr(i_brclr),
        .i_grant(i_grant), .i_nack(i_nack), .o_valid(o_valid), .o_request(o_request),
        .o_priority(o_priority), .o_rslot(o_rslot), .o_data(o_data));

    function automatic logic [WI-1:0] mk(input logic [3:0] b, input logic [2:0] t, input logic [5:0] rd,
                                         input logic [5:0] rs1, input logic [5:0] rs0, input logic [1:0] pry,
                                         input logic v, input logic [1:0] p);
        return {b, t, rd, rs1, rs0, pry, v, p};
    endfunction

    function automatic logic hit(input logic [REG-1:0] t);
        for (int j = 0; j < NWB; j++)
            if (i_wdest_vld[j] && i_wdest[j*REG +: REG] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clr_inputs();
        i_en = 0; i_data = '0; i_wdest = '0; i_wdest_vld = '0;
        i_brkill = '0; i_brclr = '0; i_grant = 0; i_nack = 0;
    endtask

    task automatic test_reset();
        clr_inputs();
        i_rst_n = 0;
        #3;
        n_total++; if ({o_valid, o_request, o_priority, o_rslot, o_data} !== '0)
            $display("FAIL reset_outputs: got %0h required 0", {o_valid, o_request, o_priority, o_rslot, o_data});
        else n_pass++;
        #10 i_rst_n = 1;
        tick();
    endtask

    task automatic test_wakeup();
        i_en = 1; i_data = mk(4'b0001, 3'b010, 6'd7, 6'd1, 6'd3, 2'd0, 1'b1, 2'b00);
        tick();
        i_en = 0; i_wdest[0*REG +: REG] = 6'd1; i_wdest_vld = 4'b0001;
        #1;
        n_total++; if (o_valid !== 1'b1 || o_request !== 1'b0)
            $display("FAIL wake_written: got v=%0b r=%0b required v=1 r=0", o_valid, o_request);
        else n_pass++;
        tick();
        clr_inputs();
        #1;
        n_total++; if (o_request !== 1'b0 || o_data[1:0] !== 2'b10)
            $display("FAIL wake_partial: got r=%0b p=%0b required r=0 p=10", o_request, o_data[1:0]);
        else n_pass++;
        i_wdest[2*REG +: REG] = 6'd3; i_wdest_vld = 4'b0100;
        #1;
        n_total++; if (o_request !== 1'b0)
            $display("FAIL wake_same_cycle: got r=%0b required 0", o_request);
        else n_pass++;
        tick();
        clr_inputs();
        #1;
        n_total++; if (o_request !== 1'b1)
            $display("FAIL wake_ready: got r=%0b required 1", o_request);
        else n_pass++;
        n_total++; if (o_rslot !== {4'b0001, 3'b010, 6'd7, 6'd1, 6'd3})
            $display("FAIL wake_rslot: got %0h required %0h", o_rslot, {4'b0001, 3'b010, 6'd7, 6'd1, 6'd3});
        else n_pass++;
    endtask

    task automatic test_bypass();
        i_en = 1; i_data = mk(4'b0000, 3'b001, 6'd9, 6'd5, 6'd5, 2'd1, 1'b1, 2'b00);
        i_wdest[3*REG +: REG] = 6'd5; i_wdest_vld = 4'b1000;
        tick();
        clr_inputs();
        #1;
        n_total++; if (o_valid !== 1'b1 || o_request !== 1'b1)
            $display("FAIL bypass: got v=%0b r=%0b required v=1 r=1", o_valid, o_request);
        else n_pass++;
    endtask

    task automatic test_issue_replay();
        i_grant = 1;
        tick();
        i_grant = 0;
        #1;
        n_total++; if (o_valid !== 1'b1 || o_request !== 1'b0)
            $display("FAIL issued: got v=%0b r=%0b required v=1 r=0", o_valid, o_request);
        else n_pass++;
        i_nack = 1;
        tick();
        i_nack = 0;
        #1;
        n_total++; if (o_request !== 1'b1)
            $display("FAIL replay_rerequest: got r=%0b required 1", o_request);
        else n_pass++;
        i_grant = 1;
        tick();
        i_grant = 0;
        tick();
        n_total++; if (o_valid !== 1'b0)
            $display("FAIL issue_retire: got v=%0b required 0", o_valid);
        else n_pass++;
    endtask

    task automatic test_kill();
        i_en = 1; i_data = mk(4'b0001, 3'b011, 6'd2, 6'd4, 6'd6, 2'd0, 1'b1, 2'b11);
        tick();
        i_en = 0; i_brkill = 4'b0111;
        #1;
        n_total++; if (o_request !== 1'b0)
            $display("FAIL kill_request: got r=%0b required 0", o_request);
        else n_pass++;
        i_grant = 1;
        tick();
        clr_inputs();
        #1;
        n_total++; if (o_valid !== 1'b0)
            $display("FAIL kill_valid: got v=%0b required 0", o_valid);
        else n_pass++;
        i_en = 1; i_data = mk(4'b0001, 3'b011, 6'd2, 6'd4, 6'd6, 2'd0, 1'b1, 2'b11);
        tick();
        i_en = 0; i_brclr = 4'b0001;
        tick();
        i_brclr = 0; i_brkill = 4'b0001;
        #1;
        n_total++; if (o_request !== 1'b1)
            $display("FAIL clear_request: got r=%0b required 1", o_request);
        else n_pass++;
        tick();
        i_brkill = 0;
        #1;
        n_total++; if (o_valid !== 1'b1 || o_rslot[WO-1 -: BRM] !== 4'b0000)
            $display("FAIL clear_survive: got v=%0b brm=%0b required v=1 brm=0000", o_valid, o_rslot[WO-1 -: BRM]);
        else n_pass++;
        i_en = 1; i_data = mk(4'b0010, 3'b011, 6'd2, 6'd4, 6'd6, 2'd0, 1'b1, 2'b11);
        tick();
        i_en = 0; i_brclr = 4'b0010; i_brkill = 4'b0010;
        tick();
        clr_inputs();
        #1;
        n_total++; if (o_valid !== 1'b0)
            $display("FAIL kill_beats_clear: got v=%0b required 0", o_valid);
        else n_pass++;
    endtask

    task automatic test_write_cases();
        i_en = 1; i_data = mk(4'b0000, 3'b001, 6'd8, 6'd1, 6'd2, 2'd0, 1'b0, 2'b11);
        tick();
        i_en = 0;
        #1;
        n_total++; if (o_valid !== 1'b0)
            $display("FAIL write_val0: got v=%0b required 0", o_valid);
        else n_pass++;
        i_en = 1; i_data = mk(4'b0000, 3'b001, 6'd8, 6'd1, 6'd2, 2'd0, 1'b1, 2'b11);
        tick();
        i_en = 0; i_grant = 1;
        tick();
        i_grant = 0; i_nack = 1;
        i_en = 1; i_data = mk(4'b0000, 3'b100, 6'd9, 6'd20, 6'd21, 2'd0, 1'b1, 2'b00);
        tick();
        clr_inputs();
        #1;
        n_total++; if (o_valid !== 1'b1 || o_request !== 1'b0 || o_rslot !== '0 || o_data[O_RD +: REG] !== 6'd9)
            $display("FAIL write_over_issued: got v=%0b r=%0b rslot=%0h rd=%0d required v=1 r=0 rslot=0 rd=9",
                     o_valid, o_request, o_rslot, o_data[O_RD +: REG]);
        else n_pass++;
    endtask

    task automatic test_priority();
        logic [PRY-1:0] exp_age [5];
        exp_age[0] = 0; exp_age[1] = 1; exp_age[2] = 2; exp_age[3] = 3; exp_age[4] = 3;
        i_en = 1; i_data = mk(4'b0000, 3'b101, 6'd12, 6'd10, 6'd11, 2'd2, 1'b1, 2'b00);
        tick();
        i_en = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
`ifdef ISSUE_SLOT_AGE_EN
            n_total++; if (o_priority !== exp_age[i])
                $display("FAIL age_wait%0d: got %0d required %0d", i, o_priority, exp_age[i]);
            else n_pass++;
`else
            n_total++; if (o_priority !== 2'd2)
                $display("FAIL pry_wait%0d: got %0d required 2 (age %0d unused)", i, o_priority, exp_age[i]);
            else n_pass++;
`endif
            tick();
        end
        i_wdest[0 +: REG] = 6'd10; i_wdest[REG +: REG] = 6'd11; i_wdest_vld = 4'b0011;
        tick();
        clr_inputs(); i_grant = 1;
        tick();
        i_grant = 0; i_nack = 1;
        tick();
        i_nack = 0;
        #1;
`ifdef ISSUE_SLOT_AGE_EN
        n_total++; if (o_request !== 1'b1 || o_priority !== 2'd3)
            $display("FAIL age_replay: got r=%0b pri=%0d required r=1 pri=3", o_request, o_priority);
        else n_pass++;
`else
        n_total++; if (o_request !== 1'b1 || o_priority !== 2'd2)
            $display("FAIL pry_replay: got r=%0b pri=%0d required r=1 pri=2", o_request, o_priority);
        else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        i_en = 1; i_data = mk(4'b0000, 3'b001, 6'd3, 6'd1, 6'd2, 2'd3, 1'b1, 2'b11);
        tick();
        clr_inputs();
        #2 i_rst_n = 0;
        #1;
        n_total++; if (o_valid !== 1'b0 || o_data !== '0 || o_priority !== '0)
            $display("FAIL async_reset: got v=%0b data=%0h pri=%0d required all 0", o_valid, o_data, o_priority);
        else n_pass++;
        #4 i_rst_n = 1;
        tick();
    endtask

    task automatic test_random();
        logic [WI-1:0]  e_data;
        logic [WO-1:0]  e_rslot;
        logic [PRY-1:0] e_pri;
        logic [NS-1:0]  pnew, pin;
        logic [REG-1:0] in_rs [NS];
        logic           killed, e_req, kill_in;
        int             hold, bad;
        m_st = 0; m_brm = 0; m_tag = 0; m_rd = 0; m_pry = 0; m_age = 0; m_p = 0;
        for (int k = 0; k < NS; k++) m_rs[k] = 0;
        bad = 0;
        for (int c = 0; c < 600; c++) begin
            i_en = ($urandom_range(0, 3) == 0);
            i_data = mk(4'($urandom_range(0, 15)), 3'($urandom), 6'($urandom), 6'($urandom_range(0, 7)),
                        6'($urandom_range(0, 7)), 2'($urandom), ($urandom_range(0, 7) != 0), 2'($urandom));
            for (int j = 0; j < NWB; j++) i_wdest[j*REG +: REG] = 6'($urandom_range(0, 7));
            i_wdest_vld = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            i_brkill = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            i_brclr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            i_grant = 1'($urandom);
            i_nack = 1'($urandom);
            #1;
            killed = (m_st != 0) && ((m_brm & i_brkill) != 0);
            e_req = (m_st == 2) && ((m_brm & i_brkill) == 0);
            for (int k = 0; k < NS; k++) pnew[k] = m_p[k] | hit(m_rs[k]);
            if (killed) hold = 0;
            else if (m_st == 1) hold = (&pnew) ? 2 : 1;
            else if (m_st == 2) hold = (e_req && i_grant) ? 3 : 2;
            else if (m_st == 3) hold = i_nack ? 2 : 0;
            else hold = 0;
            e_rslot = (m_st == 2 || m_st == 3) ? {m_brm, m_tag, m_rd, m_rs[1], m_rs[0]} : '0;
            e_data = {m_brm & ~i_brclr, m_tag, m_rd, m_rs[1], m_rs[0], m_pry, (hold == 1 || hold == 2), pnew};
`ifdef ISSUE_SLOT_AGE_EN
            e_pri = m_age;
`else
            e_pri = m_pry;
`endif
            n_total++; if (o_valid !== (m_st != 0) || o_request !== e_req || o_priority !== e_pri) begin
                if (bad < 10) $display("FAIL rnd_ctrl c=%0d: got v=%0b r=%0b pri=%0d required v=%0b r=%0b pri=%0d",
                                       c, o_valid, o_request, o_priority, (m_st != 0), e_req, e_pri);
                bad++;
            end else n_pass++;
            n_total++; if (o_rslot !== e_rslot || o_data !== e_data) begin
                if (bad < 10) $display("FAIL rnd_data c=%0d: got rslot=%0h data=%0h required rslot=%0h data=%0h",
                                       c, o_rslot, o_data, e_rslot, e_data);
                bad++;
            end else n_pass++;
            if (i_en) begin
                for (int k = 0; k < NS; k++) begin
                    in_rs[k] = i_data[5 + k*REG +: REG];
                    pin[k] = i_data[k] | hit(in_rs[k]);
                end
                kill_in = (i_data[O_BRM +: BRM] & i_brkill) != 0;
                m_st = (killed || kill_in || !i_data[2]) ? 0 : ((&pin) ? 2 : 1);
                m_brm = i_data[O_BRM +: BRM] & ~i_brclr;
                m_tag = i_data[23 +: TAG];
                m_rd = i_data[O_RD +: REG];
                for (int k = 0; k < NS; k++) m_rs[k] = in_rs[k];
                m_pry = i_data[3 +: PRY];
                m_p = pin;
                m_age = 0;
            end else begin
                if (m_st == 3 && i_nack) m_age = '1;
                else if ((m_st == 1 || m_st == 2) && m_age != '1) m_age = m_age + 1'b1;
                m_st = hold;
                m_brm = m_brm & ~i_brclr;
                m_p = pnew;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_wakeup();
        test_bypass();
        test_issue_replay();
        test_kill();
        test_write_cases();
        test_priority();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
